// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous clock in i_clk cycles.
// One measurement per i_start; results held until the next successful measurement.
module clk_period_meter #(
  parameter int P_CNT_WIDTH = 16,
  parameter int P_TIMEOUT   = 65535
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_sig,
  input  logic                   i_start,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic [P_CNT_WIDTH-1:0] o_period,
  output logic [P_CNT_WIDTH-1:0] o_high,
  output logic                   o_timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  localparam logic [P_CNT_WIDTH-1:0] ONE      = P_CNT_WIDTH'(1);
  localparam logic [P_CNT_WIDTH-1:0] TMO_LAST = P_CNT_WIDTH'(P_TIMEOUT - 1);

  state_t state, state_nxt;

  logic sync1, sync2, sig_d;
  logic rise, fall;

  logic [P_CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [P_CNT_WIDTH-1:0] high_reg, high_reg_nxt;
  logic [P_CNT_WIDTH-1:0] timer, timer_nxt;
  logic [P_CNT_WIDTH-1:0] period_nxt, high_out_nxt;
  logic                   valid_nxt, timeout_nxt;
  logic                   tmo_hit;

  // Two-flop synchronizer plus one edge flop: rise and fall see identical latency.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sig_d <= 1'b0;
    end else begin
      sync1 <= i_sig;
      sync2 <= sync1;
      sig_d <= sync2;
    end
  end

  assign rise    = sync2 & ~sig_d;
  assign fall    = ~sync2 & sig_d;
  assign tmo_hit = (timer == TMO_LAST);
  assign o_busy  = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      high_reg  <= '0;
      timer     <= '0;
      o_period  <= '0;
      o_high    <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      high_reg  <= high_reg_nxt;
      timer     <= timer_nxt;
      o_period  <= period_nxt;
      o_high    <= high_out_nxt;
      o_valid   <= valid_nxt;
      o_timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    high_reg_nxt = high_reg;
    timer_nxt    = timer;
    period_nxt   = o_period;
    high_out_nxt = o_high;
    valid_nxt    = 1'b0;
    timeout_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt = WAIT_EDGE;
          timer_nxt = '0;
        end
      end

      WAIT_EDGE: begin
        timer_nxt = timer + ONE;
        // A rise here only opens the window, so it cannot rescue a timeout.
        if (tmo_hit) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end else if (rise) begin
          cnt_nxt      = ONE;
          high_reg_nxt = '0;
          state_nxt    = MEASURE;
        end
      end

      MEASURE: begin
        timer_nxt = timer + ONE;
        if (rise) begin
          period_nxt   = cnt;
          high_out_nxt = high_reg;
          valid_nxt    = 1'b1;
          state_nxt    = IDLE;
        end else begin
          cnt_nxt = cnt + ONE;
          if (fall) high_reg_nxt = cnt;
          if (tmo_hit) begin
            state_nxt   = IDLE;
            timeout_nxt = 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized bench: i_sig comes from a (high, low) waveform generator and the
// expected period/high time are simply high+low and high.
module tb_clk_period_meter;

  localparam int W   = 16;
  localparam int TMO = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sig = 1'b0;
  logic         start = 1'b0;
  logic         busy, valid, timeout;
  logic [W-1:0] period, high;

  int n_chk  = 0;
  int n_fail = 0;

  // 0: stuck low, 1: stuck high, 2: periodic with gen_hi/gen_lo
  int gen_mode = 0;
  int gen_hi   = 1;
  int gen_lo   = 1;
  int ph       = 0;

  clk_period_meter #(.P_CNT_WIDTH(W), .P_TIMEOUT(TMO)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_sig     (sig),
    .i_start   (start),
    .o_busy    (busy),
    .o_valid   (valid),
    .o_period  (period),
    .o_high    (high),
    .o_timeout (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      case (gen_mode)
        0: sig = 1'b0;
        1: sig = 1'b1;
        default: begin
          sig = (ph < gen_hi);
          ph  = ph + 1;
          if (ph >= gen_hi + gen_lo) ph = 0;
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one measurement of a (hi, lo) waveform, optionally poking i_start while busy.
  task automatic measure(input int hi, input int lo, input bit extra);
    int cyc;
    int tmo_seen;
    int pulses;
    bit got_valid;
    gen_hi   = hi;
    gen_lo   = lo;
    gen_mode = 2;
    repeat (hi + lo + 4 + $urandom_range(0, hi + lo)) tick();
    pulse_start();
    tmo_seen  = 0;
    got_valid = 1'b0;
    for (cyc = 0; cyc < 200; cyc++) begin
      tick();
      if (timeout) tmo_seen++;
      if (valid) begin
        got_valid = 1'b1;
        break;
      end
      start = extra && busy && ($urandom_range(0, 2) == 0);
    end
    start = 1'b0;
    check("valid_seen", 32'(got_valid), 1);
    if (got_valid) begin
      check("period", 32'(period), 32'(hi + lo));
      check("high", 32'(high), 32'(hi));
      check("busy_on_valid", 32'(busy), 0);
      check("no_tmo_in_meas", 32'(tmo_seen), 0);
      tick();
      check("valid_one_cycle", 32'(valid), 0);
      check("busy_after_valid", 32'(busy), 0);
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
        tick();
        pulses += int'(valid) + int'(timeout) + int'(busy);
      end
      check("quiet_after_result", 32'(pulses), 0);
    end
  endtask

  // Counts ticks until o_timeout, counting any o_valid seen on the way.
  task automatic wait_timeout(output int k, output int vcount);
    k = 0;
    vcount = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      k++;
      if (valid) vcount++;
      if (timeout) break;
    end
  endtask

  task automatic timeout_case(input int mode);
    logic [W-1:0] per0, hi0;
    int k, vc;
    gen_mode = mode;
    repeat (12) tick();
    per0 = period;
    hi0  = high;
    pulse_start();
    wait_timeout(k, vc);
    check("tmo_latency", 32'(k), TMO);
    check("tmo_no_valid", 32'(vc), 0);
    check("tmo_busy_low", 32'(busy), 0);
    check("tmo_period_kept", 32'(period), 32'(per0));
    check("tmo_high_kept", 32'(high), 32'(hi0));
    // Start on the pulse cycle must be accepted.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("tmo_one_cycle", 32'(timeout), 0);
    check("start_on_tmo_pulse", 32'(busy), 1);
    wait_timeout(k, vc);
    check("tmo2_latency", 32'(k), TMO);
    check("tmo2_no_valid", 32'(vc), 0);
  endtask

  task automatic reset_mid_measure();
    int bad;
    gen_mode = 0;
    repeat (8) tick();
    pulse_start();
    repeat (4) tick();
    gen_hi   = 10;
    gen_lo   = 10;
    ph       = 0;
    gen_mode = 2;
    repeat (9) tick();
    check("busy_before_rst", 32'(busy), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_outputs", {period, high}, 0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bad += int'(valid) + int'(timeout) + int'(busy);
    end
    check("rst_no_pulses", 32'(bad), 0);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      bad += int'(valid) + int'(timeout) + int'(busy);
    end
    check("post_rst_waits", 32'(bad), 0);
    measure(4, 7, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    check("reset_busy", 32'(busy), 0);
    check("reset_valid", 32'(valid), 0);
    check("reset_timeout", 32'(timeout), 0);
    check("reset_period", 32'(period), 0);
    check("reset_high", 32'(high), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();

    measure(3, 3, 1'b0);
    measure(1, 1, 1'b0);
    measure(5, 11, 1'b0);
    measure(5, 11, 1'b0);
    measure(6, 9, 1'b1);

    for (int t = 0; t < 8; t++) begin
      measure($urandom_range(1, 15), $urandom_range(1, 15), 1'($urandom_range(0, 1)));
    end

    timeout_case(0);
    measure(2, 3, 1'b0);
    timeout_case(1);

    reset_mid_measure();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 SHALL have parameter P_CNT_WIDTH, default 16: width of all measurement counters and result outputs.
REQ-002 SHALL have parameter P_TIMEOUT, default 65535: maximum busy cycles per measurement; legal range 4 to 2^P_CNT_WIDTH-1.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_sig, input, 1 bit: measured clock (e.g. divider output); asynchronous to i_clk.
REQ-006 SHALL have port i_start, input, 1 bit: single-cycle measurement request.
REQ-007 SHALL have port o_busy, output, 1 bit: high while a measurement is in progress.
REQ-008 SHALL have port o_valid, output, 1 bit: one-cycle pulse when new results are present.
REQ-009 SHALL have port o_period, output, P_CNT_WIDTH bits: i_clk cycles between two consecutive i_sig rising edges.
REQ-010 SHALL have port o_high, output, P_CNT_WIDTH bits: i_clk cycles i_sig was high within that period.
REQ-011 SHALL have port o_timeout, output, 1 bit: one-cycle pulse when a measurement is aborted.

Function
REQ-012 SHALL pass i_sig through a 2-flop synchronizer, then a 1-flop edge register; rise and fall are detected on the synchronized signal, with a fixed latency of 3 cycles for both edges.
REQ-013 SHALL implement FSM states IDLE, WAIT_EDGE, MEASURE; o_busy SHALL be high exactly in WAIT_EDGE and MEASURE.
REQ-014 In IDLE, i_start=1 SHALL move the FSM to WAIT_EDGE and clear the timeout timer; i_start SHALL be ignored in every other state.
REQ-015 In WAIT_EDGE, a detected rise SHALL load the period counter with 1 and move the FSM to MEASURE.
REQ-016 In MEASURE, each cycle without a rise SHALL increment the period counter; a detected fall SHALL capture the current counter value into the high register.
REQ-017 In MEASURE, a detected rise SHALL load o_period with the counter value and o_high with the high register, assert o_valid for the next cycle only, and return the FSM to IDLE.
REQ-018 The timeout timer SHALL increment on every busy cycle; when it reaches P_TIMEOUT-1 without a completing rise, o_timeout SHALL pulse for one cycle, the FSM SHALL return to IDLE, and o_period and o_high SHALL keep their old values.
REQ-019 If a completing rise and the timeout condition occur in the same cycle, the measurement SHALL complete (o_valid=1) and o_timeout SHALL stay 0.
REQ-020 Counters SHALL never wrap: P_TIMEOUT bounds them below 2^P_CNT_WIDTH.
REQ-021 o_period and o_high SHALL hold their values until the next successful measurement.
REQ-022 o_valid and o_timeout SHALL never be high in the same cycle; i_start accepted on the same cycle as either pulse SHALL start a new measurement.

Reset
REQ-023 While i_rst=0, the FSM SHALL be in IDLE, the synchronizer and edge flops SHALL be 0, all counters SHALL be 0, and o_busy, o_valid, o_timeout, o_period and o_high SHALL be 0.
REQ-024 Reset asserted mid-measurement SHALL abort the measurement immediately, with no o_valid or o_timeout pulse; after release, the block SHALL wait for a new i_start.

Verification
REQ-025 Bench SHALL cover: i_sig toggling every 3 i_clk cycles, then i_start -> one o_valid pulse with o_period=6, o_high=3, and o_busy low the following cycle.
REQ-026 Bench SHALL cover: i_sig toggling every cycle (period 2) -> o_period=2, o_high=1.
REQ-027 Bench SHALL cover: i_sig high 5 cycles and low 11 cycles -> o_period=16, o_high=5; a repeated i_start gives identical results.
REQ-028 Bench SHALL cover: P_TIMEOUT=100 with i_sig stuck at 0, then i_start -> o_timeout pulse 100 cycles after i_start is accepted, o_valid stays 0, and o_period is unchanged.
REQ-029 Bench SHALL cover: i_start pulses while o_busy=1 -> ignored; exactly one result is produced.
REQ-030 Bench SHALL cover: i_rst driven low during MEASURE -> all outputs 0 within the reset assertion, no pulses; after release, i_start gives a correct new measurement.
